red_pitaya_pll_drp: RTL and testbench
=====================================

// Module: red_pitaya_pll_drp
// PURPOSE
//  DRP master for a PLLE2_ADV: serialises host register requests into DRP read / read-modify-write cycles.
//  Holds the PLL in reset across a write batch, then releases it and waits for lock.
//  Sits between the housekeeping register bank and the PLL; DCLK is driven from the same clk.
// PARAMETERS
//  DRDY_TO  = 64      max clk cycles from DEN to DRDY before timeout error
//  LOCK_TO  = 100000  max clk cycles after PLL reset release to wait for pll_locked
//  LOCK_CNT = 16      consecutive locked cycles required before lock is accepted
// PORTS
//  clk         in   1   system clock, also drives PLL DCLK
//  rstn        in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   block idle, request accepted when req_valid&&req_ready
//  req_we      in   1   1=read-modify-write, 0=read only
//  req_last    in   1   last write of a batch: release PLL reset and wait for lock afterwards
//  req_addr    in   7   DRP register address
//  req_mask    in   16  1=keep old bit, 0=take req_wdata bit
//  req_wdata   in   16  write data
//  rsp_valid   out  1   one-cycle response strobe
//  rsp_rdata   out  16  DRP read value (pre-write value for RMW)
//  rsp_err     out  2   0 ok, 1 DRDY timeout, 2 lock timeout, 3 verify mismatch
//  busy        out  1   transaction or PLL reset in progress
//  drp_daddr   out  7   to PLL DADDR
//  drp_den     out  1   to PLL DEN
//  drp_dwe     out  1   to PLL DWE
//  drp_di      out  16  to PLL DI
//  drp_do      in   16  from PLL DO
//  drp_drdy    in   1   from PLL DRDY
//  pll_rst     out  1   to PLL RST, combine by OR with !rstn outside
//  pll_locked  in   1   from PLL LOCKED
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1. FSM=IDLE, counters cleared, pll_rst=0 (external !rstn resets PLL).
//  FSM: IDLE -> RD -> RD_WAIT -> [WR -> WR_WAIT -> (VFY -> VFY_WAIT)] -> [LOCK_WAIT] -> RESP -> IDLE.
//  IDLE: req_ready=1; on accept, latch addr/mask/wdata/we/last; set pll_rst=1 if req_we.
//  RD/WR/VFY: drp_den one cycle; drp_dwe=1 only in WR; drp_daddr/drp_di stable from DEN until DRDY.
//  *_WAIT: timeout counter from 0; on drp_drdy leave state; at DRDY_TO cycles go RESP with err=1.
//  RD_WAIT: capture drp_do into rsp_rdata; read-only -> RESP.
//  WR data = (rdata & req_mask) | (req_wdata & ~req_mask); computed registered in WR_WAIT entry.
//  After WR_WAIT (or VFY_WAIT): last=1 -> pll_rst=0, LOCK_WAIT; last=0 -> RESP with pll_rst held 1.
//  LOCK_WAIT: stability counter increments while pll_locked, clears on any low; LOCK_CNT reached -> RESP ok.
//   Total LOCK_TO exceeded -> RESP err=2.
//  Any error: pll_rst forced 0 (PLL released), batch aborted.
//  RESP: rsp_valid=1 one cycle, rsp_rdata/rsp_err held until next request; then IDLE.
//  drp_drdy outside a *_WAIT state: ignored. req_valid while busy: not accepted.
//  Accepting the request and DEN: no same-cycle; RD DEN follows accept by 1 cycle.
//  Minimum latency: read 4 cycles accept->rsp_valid with DRDY in 1 cycle.
//  rstn low mid-transaction: immediate return to reset values; no response issued.
// CONFIGURATION
//  PLL_DRP_VERIFY_EN defined: after each write, re-read the address (VFY/VFY_WAIT).
//   Readback != written word -> err=3, PLL released.
//  Not defined: VFY states absent; WR_WAIT proceeds directly; err=3 never produced.
// STRUCTURE
//  red_pitaya_pll_drp_pkg: FSM state enum, rsp_err codes, PLLE2 DRP address constants.
//   Constants: CLKOUT0_REG1=7'h08, CLKOUT0_REG2=7'h09, CLKFBOUT_REG1=7'h14, DIVCLK=7'h16, LOCK_REG1=7'h18, POWER=7'h28.
//  No sub-module: one shared timeout counter; one lock-stability counter.
// TESTING
//  Bench uses a DRP responder model: 16-bit register array, DRDY N cycles after DEN, LOCKED M cycles after RST falls.
//  Read addr 0x08, mem=0x1041, DRDY after 2 -> rsp_rdata=0x1041, err=0, pll_rst never high.
//  RMW addr 0x08, mem=0x1041, mask=0xF000, wdata=0x0082, last=1 -> mem=0x1082; pll_rst 1 then 0; rsp after LOCK_CNT locked cycles.
//  Two-write batch (last=0 then last=1) -> pll_rst stays 1 between requests; exactly one release.
//  Responder never asserts DRDY -> rsp_err=1 after DRDY_TO cycles; pll_rst=0; next request accepted.
//  LOCKED glitches low once mid-count -> stability counter restarts. LOCKED never high -> err=2 at LOCK_TO.
//  VERIFY_EN with model corrupting bit0 on write -> err=3. Separately, rstn low during WR_WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/red_pitaya_pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP master.
// The VFY states exist only when PLL_DRP_VERIFY_EN is defined.
package red_pitaya_pll_drp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
`ifdef PLL_DRP_VERIFY_EN
    ST_VFY,
    ST_VFY_WAIT,
`endif
    ST_LOCK_WAIT,
    ST_RESP
  } drp_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_DRDY_TO = 2'd1,
    ERR_LOCK_TO = 2'd2,
    ERR_VERIFY  = 2'd3
  } drp_err_t;

  localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] DIVCLK        = 7'h16;
  localparam logic [6:0] LOCK_REG1     = 7'h18;
  localparam logic [6:0] POWER         = 7'h28;

  // Mask bit 1 keeps the bit read back from the PLL, 0 takes the new data bit.
  function automatic logic [15:0] drp_merge(input logic [15:0] old_word,
                                            input logic [15:0] mask,
                                            input logic [15:0] wdata);
    return (old_word & mask) | (wdata & ~mask);
  endfunction

endpackage

// File: rtl/red_pitaya_pll_drp.sv
// DRP master for PLLE2_ADV: read / read-modify-write cycles, PLL reset across write batches, lock wait.
// Define PLL_DRP_VERIFY_EN to re-read every written register and flag a readback mismatch.
module red_pitaya_pll_drp
  import red_pitaya_pll_drp_pkg::*;
#(
  parameter int DRDY_TO  = 64,
  parameter int LOCK_TO  = 100000,
  parameter int LOCK_CNT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_last,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int TMR_MAX = (LOCK_TO > DRDY_TO) ? LOCK_TO : DRDY_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_CNT + 1);

  localparam logic [TMR_W-1:0] DRDY_LIM = TMR_W'(DRDY_TO - 1);
  localparam logic [TMR_W-1:0] LOCK_LIM = TMR_W'(LOCK_TO - 1);
  localparam logic [STB_W-1:0] STB_LIM  = STB_W'(LOCK_CNT - 1);

  drp_state_t        state;
  logic [TMR_W-1:0]  tmr;
  logic [STB_W-1:0]  stb;
  logic [15:0]       lat_mask;
  logic [15:0]       lat_wdata;
  logic              lat_we;
  logic              lat_last;
  logic [15:0]       wr_word;

  // A batch in progress keeps busy high between requests while still accepting the next one.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE) || pll_rst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      stb       <= '0;
      lat_mask  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_last  <= 1'b0;
      wr_word   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
      drp_daddr <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= '0;
      pll_rst   <= 1'b0;
    end else begin
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            drp_daddr <= req_addr;
            lat_mask  <= req_mask;
            lat_wdata <= req_wdata;
            lat_we    <= req_we;
            lat_last  <= req_last;
            pll_rst   <= pll_rst | req_we;
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          drp_den <= 1'b1;
          tmr     <= '0;
          state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (drp_drdy) begin
            rsp_rdata <= drp_do;
            wr_word   <= drp_merge(drp_do, lat_mask, lat_wdata);
            rsp_err   <= ERR_OK;
            state     <= lat_we ? ST_WR : ST_RESP;
          end else if (tmr == DRDY_LIM) begin
            rsp_err <= ERR_DRDY_TO;
            pll_rst <= 1'b0;
            state   <= ST_RESP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WR: begin
          drp_den <= 1'b1;
          drp_dwe <= 1'b1;
          drp_di  <= wr_word;
          tmr     <= '0;
          state   <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (drp_drdy) begin
`ifdef PLL_DRP_VERIFY_EN
            state <= ST_VFY;
`else
            if (lat_last) begin
              pll_rst <= 1'b0;
              tmr     <= '0;
              stb     <= '0;
              state   <= ST_LOCK_WAIT;
            end else begin
              rsp_err <= ERR_OK;
              state   <= ST_RESP;
            end
`endif
          end else if (tmr == DRDY_LIM) begin
            rsp_err <= ERR_DRDY_TO;
            pll_rst <= 1'b0;
            state   <= ST_RESP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`ifdef PLL_DRP_VERIFY_EN
        ST_VFY: begin
          drp_den <= 1'b1;
          tmr     <= '0;
          state   <= ST_VFY_WAIT;
        end
        ST_VFY_WAIT: begin
          if (drp_drdy) begin
            if (drp_do != wr_word) begin
              rsp_err <= ERR_VERIFY;
              pll_rst <= 1'b0;
              state   <= ST_RESP;
            end else if (lat_last) begin
              pll_rst <= 1'b0;
              tmr     <= '0;
              stb     <= '0;
              state   <= ST_LOCK_WAIT;
            end else begin
              rsp_err <= ERR_OK;
              state   <= ST_RESP;
            end
          end else if (tmr == DRDY_LIM) begin
            rsp_err <= ERR_DRDY_TO;
            pll_rst <= 1'b0;
            state   <= ST_RESP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`endif
        // Lock is accepted only after LOCK_CNT consecutive high samples.
        ST_LOCK_WAIT: begin
          if (pll_locked && (stb == STB_LIM)) begin
            rsp_err <= ERR_OK;
            state   <= ST_RESP;
          end else if (tmr == LOCK_LIM) begin
            rsp_err <= ERR_LOCK_TO;
            state   <= ST_RESP;
          end else begin
            tmr <= tmr + 1'b1;
            stb <= pll_locked ? stb + 1'b1 : '0;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_pll_drp.sv
// Directed bench for red_pitaya_pll_drp with a DRP/PLL responder model.
// Build with PLL_DRP_VERIFY_EN defined to exercise the readback check.
module tb_red_pitaya_pll_drp;

  localparam int DRDY_TO  = 64;
  localparam int LOCK_TO  = 200;
  localparam int LOCK_CNT = 16;
  localparam int LOCK_M   = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_last = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [15:0] req_mask = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        pll_rst;
  logic        pll_locked;

  red_pitaya_pll_drp #(
    .DRDY_TO  (DRDY_TO),
    .LOCK_TO  (LOCK_TO),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .pll_rst    (pll_rst),
    .pll_locked (pll_locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder controls: ndrdy=0 never answers; drop_wr ignores write DENs.
  int   ndrdy = 1;
  bit   drop_wr = 1'b0;
  bit   corrupt = 1'b0;
  int   lock_mode = 0;
  bit   pl_go = 1'b0;
  logic [6:0]  pl_a = '0;
  logic [15:0] pl_v = '0;

  logic [15:0] mem [128];
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [6:0]  pa = '0;
  logic        pw = 1'b0;
  logic [15:0] pd = '0;
  int          lcnt = 0;

  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (pl_go) mem[pl_a] <= pl_v;
    if (!rstn) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (pcnt == 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= mem[pa];
          if (pw) mem[pa] <= corrupt ? (pd ^ 16'h0001) : pd;
          pend <= 1'b0;
        end else begin
          pcnt <= pcnt - 1;
        end
      end
      if (drp_den && (ndrdy != 0) && !(drp_dwe && drop_wr)) begin
        if (ndrdy == 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= mem[drp_daddr];
          if (drp_dwe) mem[drp_daddr] <= corrupt ? (drp_di ^ 16'h0001) : drp_di;
        end else begin
          pend <= 1'b1;
          pcnt <= ndrdy - 1;
          pa   <= drp_daddr;
          pw   <= drp_dwe;
          pd   <= drp_di;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (pll_rst) lcnt <= 0;
    else if (lcnt < 100000) lcnt <= lcnt + 1;
  end

  assign pll_locked = (lock_mode != 1) && !pll_rst && (lcnt >= LOCK_M) &&
                      !((lock_mode == 2) && (lcnt == LOCK_M + 5));

  int   rises = 0;
  int   falls = 0;
  int   fall_cyc = 0;
  int   rsp_cnt = 0;
  int   wr_den_cnt = 0;
  logic prev_rst = 1'b0;

  always @(negedge clk) begin
    if (!prev_rst && pll_rst) rises = rises + 1;
    if (prev_rst && !pll_rst) begin
      falls    = falls + 1;
      fall_cyc = cyc;
    end
    prev_rst = pll_rst;
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (drp_den && drp_dwe) wr_den_cnt = wr_den_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [15:0] v);
    @(negedge clk);
    pl_a  = a;
    pl_v  = v;
    pl_go = 1'b1;
    @(posedge clk);
    #1 pl_go = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic last, input logic [6:0] addr,
                        input logic [15:0] mask, input logic [15:0] wdata);
    int n;
    @(negedge clk);
    req_we    = we;
    req_last  = last;
    req_addr  = addr;
    req_mask  = mask;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int bound, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp"}, rsp_valid, 1'b1);
    lat = cyc - acc_cyc;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_ctrl"}, {busy, rsp_valid, rsp_err, pll_rst, drp_den, drp_dwe}, 64'h0);
    check({tag, "_data"}, {rsp_rdata, drp_di, drp_daddr}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0;
    int f0;
    int c0;
    int w0;
    int n;

    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Minimum read latency with DRDY one cycle after DEN
    preload(7'h16, 16'h0041);
    ndrdy = 1;
    do_req("rd_min", 1'b0, 1'b0, 7'h16, 16'h0, 16'h0);
    wait_rsp("rd_min", 100, lat);
    check("rd_min_lat", lat, 4);
    check("rd_min_data", rsp_rdata, 16'h0041);

    // Plain read, DRDY after 2
    preload(7'h08, 16'h1041);
    ndrdy = 2;
    r0 = rises;
    do_req("rd", 1'b0, 1'b0, 7'h08, 16'h0, 16'h0);
    wait_rsp("rd", 100, lat);
    check("rd_data", rsp_rdata, 16'h1041);
    check("rd_err", rsp_err, 2'd0);
    check("rd_lat", lat, 5);
    check("rd_no_pllrst", rises - r0, 0);

    // RMW with last=1: (0x1041 & F000) | (0x0082 & 0FFF) = 0x1082
    ndrdy = 1;
    r0 = rises;
    f0 = falls;
    do_req("rmw", 1'b1, 1'b1, 7'h08, 16'hF000, 16'h0082);
    wait_rsp("rmw", 400, lat);
    check("rmw_err", rsp_err, 2'd0);
    check("rmw_rdata", rsp_rdata, 16'h1041);
    check("rmw_mem", mem[8], 16'h1082);
    check("rmw_rise", rises - r0, 1);
    check("rmw_fall", falls - f0, 1);
    check("rmw_lock_lat", cyc - fall_cyc, LOCK_M + LOCK_CNT + 1);
    check("rmw_pllrst_end", pll_rst, 1'b0);

    // Two-write batch keeps PLL in reset between requests
    preload(7'h14, 16'h5555);
    r0 = rises;
    f0 = falls;
    do_req("b1", 1'b1, 1'b0, 7'h09, 16'h0000, 16'h1234);
    wait_rsp("b1", 100, lat);
    check("b1_err", rsp_err, 2'd0);
    @(negedge clk);
    check("b1_hold", {pll_rst, busy, req_ready}, 3'b111);
    check("b1_mem", mem[9], 16'h1234);
    do_req("b2", 1'b1, 1'b1, 7'h14, 16'hFF00, 16'h00AA);
    wait_rsp("b2", 400, lat);
    check("b2_err", rsp_err, 2'd0);
    check("b2_mem", mem[20], 16'h55AA);
    check("batch_rise", rises - r0, 1);
    check("batch_fall", falls - f0, 1);

    // LOCKED glitch restarts the stability count
    lock_mode = 2;
    do_req("glitch", 1'b1, 1'b1, 7'h16, 16'hFFFF, 16'h0);
    wait_rsp("glitch", 400, lat);
    check("glitch_err", rsp_err, 2'd0);
    check("glitch_lat", cyc - fall_cyc, LOCK_M + 6 + LOCK_CNT + 1);
    lock_mode = 0;

    // DRDY never returns
    ndrdy = 0;
    do_req("drdy_to", 1'b1, 1'b1, 7'h28, 16'h0, 16'h0);
    wait_rsp("drdy_to", 400, lat);
    check("drdy_to_err", rsp_err, 2'd1);
    check("drdy_to_lat", (lat >= DRDY_TO) && (lat <= DRDY_TO + 4), 1'b1);
    @(negedge clk);
    check("drdy_to_pllrst", pll_rst, 1'b0);
    ndrdy = 1;
    do_req("after_to", 1'b0, 1'b0, 7'h08, 16'h0, 16'h0);
    wait_rsp("after_to", 100, lat);
    check("after_to_data", {rsp_err, rsp_rdata}, {2'd0, 16'h1082});

    // LOCKED never rises
    lock_mode = 1;
    do_req("lock_to", 1'b1, 1'b1, 7'h18, 16'hFFFF, 16'h0);
    wait_rsp("lock_to", 1000, lat);
    check("lock_to_err", rsp_err, 2'd2);
    check("lock_to_lat", ((cyc - fall_cyc) >= LOCK_TO) && ((cyc - fall_cyc) <= LOCK_TO + 2), 1'b1);
    @(negedge clk);
    check("lock_to_pllrst", pll_rst, 1'b0);
    lock_mode = 0;

    // Responder corrupts bit 0 of written data
    corrupt = 1'b1;
    preload(7'h28, 16'h0000);
    do_req("vfy", 1'b1, 1'b1, 7'h28, 16'h0000, 16'h0100);
    wait_rsp("vfy", 400, lat);
    check("vfy_mem", mem[40], 16'h0101);
`ifdef PLL_DRP_VERIFY_EN
    check("vfy_err", rsp_err, 2'd3);
`else
    check("vfy_err", rsp_err, 2'd0);
`endif
    @(negedge clk);
    check("vfy_pllrst", pll_rst, 1'b0);
    corrupt = 1'b0;

    // Reset asserted while stuck in WR_WAIT
    drop_wr = 1'b1;
    w0 = wr_den_cnt;
    do_req("rst_mid", 1'b1, 1'b1, 7'h08, 16'h0, 16'h0);
    n = 0;
    while (wr_den_cnt == w0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_wr_seen", wr_den_cnt - w0, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_pllrst_before", pll_rst, 1'b1);
    c0 = rsp_cnt;
    #2 rstn = 1'b0;
    #1 check_reset_outs("rst_mid");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drop_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_rsp", rsp_cnt - c0, 0);
    check("rst_mid_idle", {req_ready, busy, pll_rst}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
